axi_wr_slave: RTL and testbench

AXI3 write-channel slave that terminates the write address, write data and write response channels of the team's AXI interface and stores accepted data in an internal word-addressed memory. It is the downstream consumer of the master-side write traffic and handles FIXED, INCR and WRAP bursts of 1–16 beats with byte strobes. A side-band debug port lets the bench read memory contents directly. It supports one outstanding write transaction at a time.

---
 rtl/axi_wr_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_wr_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave.sv
// rtl/axi_wr_slave.sv - AXI3 write slave (one outstanding burst) with word memory; WRAP support under AXI_WR_SLV_WRAP_EN
module axi_wr_slave #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                     aclk,
   input  logic                     arst,
   input  logic [31:0]              awaddr,
   input  logic [3:0]               awid,
   input  logic [3:0]               awlen,
   input  logic [1:0]               awburst,
   input  logic [2:0]               awsize,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [3:0]               wid,
   input  logic [31:0]              wdata,
   input  logic [3:0]               wstrb,
   input  logic                     wlast,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [3:0]               bid,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [31:0]              dbg_data
);

   localparam int          IW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t      state_q, state_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [3:0]  bid_q, bid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [3:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   burst_type_t burst_q, burst_d;
   logic [2:0]  size_q, size_d;
   logic        err_q, err_d;
   logic        aw_err_q, aw_err_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [31:0] mem [DEPTH];

   logic        aw_hs, w_hs, b_hs;
   logic        aw_bad;
   logic [31:0] beat_bytes;
   logic [31:0] wrap_bound;
   logic [31:0] next_addr;
   logic [31:0] offset;
   logic [IW-1:0] word_idx;
   logic        in_range;
   logic        last_beat;
   logic        beat_err;
   logic        do_write;

   assign aw_hs = awvalid & awready_q;
   assign w_hs  = wvalid & wready_q;
   assign b_hs  = bvalid_q & bready;

   assign awready  = awready_q;
   assign wready   = wready_q;
   assign bvalid   = bvalid_q;
   assign bid      = bid_q;
   assign bresp    = bresp_q;
   assign dbg_data = mem[dbg_addr];

   // Errors detectable from the address phase alone; these also block every write of the burst
   always_comb begin
      aw_bad = (awsize > 3'd2) || (awburst == BURST_RSVD);
`ifdef AXI_WR_SLV_WRAP_EN
      if (awburst == BURST_WRAP) begin
         if (!((awlen == 4'd1) || (awlen == 4'd3) || (awlen == 4'd7) || (awlen == 4'd15))) begin
            aw_bad = 1'b1;
         end
         if ((awaddr & ((32'd1 << awsize) - 32'd1)) != 32'd0) begin
            aw_bad = 1'b1;
         end
      end
`else
      if (awburst == BURST_WRAP) begin
         aw_bad = 1'b1;
      end
`endif
   end

   // Address of the following beat for the captured burst type
   always_comb begin
      beat_bytes = 32'd1 << size_q;
      wrap_bound = ({28'd0, len_q} + 32'd1) << size_q;
      case (burst_q)
         BURST_INCR: next_addr = addr_q + beat_bytes;
         BURST_WRAP: next_addr = (addr_q & ~(wrap_bound - 32'd1)) |
                                 ((addr_q + beat_bytes) & (wrap_bound - 32'd1));
         default:    next_addr = addr_q;
      endcase
   end

   // Per-beat range, ID and wlast checks plus the write qualifier
   always_comb begin
      offset    = addr_q - BASE_ADDR;
      word_idx  = offset[IW+1:2];
      in_range  = (offset < SPAN);
      last_beat = (cnt_q == len_q);
      beat_err  = !in_range || (wid != id_q) || (wlast != last_beat);
      do_write  = w_hs && in_range && !aw_err_q && (wid == id_q);
   end

   // Next-state and registered-output computation for the IDLE/DATA/RESP sequence
   always_comb begin
      state_d   = state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      size_d    = size_q;
      err_d     = err_q;
      aw_err_d  = aw_err_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            awready_d = 1'b1;
            if (aw_hs) begin
               id_d      = awid;
               addr_d    = awaddr;
               len_d     = awlen;
               burst_d   = burst_type_t'(awburst);
               size_d    = awsize;
               err_d     = aw_bad;
               aw_err_d  = aw_bad;
               cnt_d     = 4'd0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (w_hs) begin
               addr_d = next_addr;
               cnt_d  = cnt_q + 4'd1;
               err_d  = err_q | beat_err;
               if (last_beat) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bid_d    = id_q;
                  bresp_d  = (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
                  state_d  = RESP;
               end
            end
         end
         RESP: begin
            if (b_hs) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
         end
      endcase
   end

   // Control and handshake registers; reset aborts any burst in flight
   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         state_q   <= IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= 4'd0;
         bresp_q   <= 2'd0;
         id_q      <= 4'd0;
         addr_q    <= 32'd0;
         len_q     <= 4'd0;
         burst_q   <= BURST_FIXED;
         size_q    <= 3'd0;
         err_q     <= 1'b0;
         aw_err_q  <= 1'b0;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         size_q    <= size_d;
         err_q     <= err_d;
         aw_err_q  <= aw_err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Byte-lane memory writes on accepted beats; contents survive reset
   always_ff @(posedge aclk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_wr_slave.sv
// tb/tb_axi_wr_slave.sv - directed self-checking bench for axi_wr_slave
module tb_axi_wr_slave;
   localparam int DEPTH = 256;

   logic        aclk = 1'b0;
   logic        arst = 1'b0;
   logic [31:0] awaddr = '0;
   logic [3:0]  awid = '0;
   logic [3:0]  awlen = '0;
   logic [1:0]  awburst = '0;
   logic [2:0]  awsize = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [3:0]  wid = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [7:0]  dbg_addr = '0;
   logic [31:0] dbg_data;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [31:0] tv_data [16];
   logic [3:0]  tv_strb [16];
   logic [3:0]  tv_wid  [16];
   logic        tv_last [16];
   logic [3:0]  got_bid;
   logic [1:0]  got_bresp;
   int          aw_cyc, b_cyc;
   logic [31:0] rv;

   axi_wr_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
      .aclk(aclk), .arst(arst),
      .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic set_beats(input int len, input logic [31:0] base, input logic [3:0] id);
      for (int i = 0; i < 16; i++) begin
         tv_data[i] = base + 32'(i);
         tv_strb[i] = 4'hF;
         tv_wid[i]  = id;
         tv_last[i] = (i == len);
      end
   endtask

   task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
      int t = 0;
      awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
      while (awready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
      if (awready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL aw_timeout awready=%b required 1", awready);
      end
      aw_cyc = cyc;
      @(negedge aclk);
      awvalid = 1'b0;
   endtask

   task automatic w_beats(input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         int t = 0;
         wvalid = 1'b1; wdata = tv_data[i]; wstrb = tv_strb[i]; wid = tv_wid[i]; wlast = tv_last[i];
         while (wready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
         if (wready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL w_timeout beat %0d wready=%b required 1", i, wready);
         end
         @(negedge aclk);
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic b_phase();
      int t = 0;
      bready = 1'b1;
      while (bvalid !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
      if (bvalid !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL b_timeout bvalid=%b required 1", bvalid);
      end
      got_bid = bid; got_bresp = bresp; b_cyc = cyc;
      @(negedge aclk);
      bready = 1'b0;
   endtask

   task automatic run_txn(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      aw_phase(addr, id, len, burst, size);
      w_beats(0, int'(len) + 1);
      b_phase();
   endtask

   task automatic wsingle(input int word, input logic [31:0] value);
      set_beats(0, value, 4'h0);
      run_txn(32'(word * 4), 4'h0, 4'd0, 2'd1, 3'd2);
   endtask

   task automatic rd(input int word, output logic [31:0] v);
      dbg_addr = 8'(word);
      #1;
      v = dbg_data;
   endtask

   task automatic test_reset();
      arst = 1'b0;
      repeat (2) @(negedge aclk);
      n_vec++; if (awready !== 1'b0) begin n_err++; $display("FAIL rst_awready got %b want 0", awready); end
      n_vec++; if (wready !== 1'b0) begin n_err++; $display("FAIL rst_wready got %b want 0", wready); end
      n_vec++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL rst_bvalid got %b want 0", bvalid); end
      n_vec++; if (bid !== 4'h0) begin n_err++; $display("FAIL rst_bid got %h want 0", bid); end
      n_vec++; if (bresp !== 2'd0) begin n_err++; $display("FAIL rst_bresp got %h want 0", bresp); end
      arst = 1'b1;
      @(negedge aclk);
      n_vec++; if (awready !== 1'b1) begin n_err++; $display("FAIL rst_awready_rise got %b want 1", awready); end
   endtask

   task automatic test_incr();
      set_beats(3, 32'hA0, 4'h5);
      run_txn(32'h10, 4'h5, 4'd3, 2'd1, 3'd2);
      n_vec++; if (got_bresp !== 2'd0) begin n_err++; $display("FAIL incr_bresp got %h want 0", got_bresp); end
      n_vec++; if (got_bid !== 4'h5) begin n_err++; $display("FAIL incr_bid got %h want 5", got_bid); end
      n_vec++; if (b_cyc - aw_cyc !== 5) begin n_err++; $display("FAIL incr_latency got %0d want 5", b_cyc - aw_cyc); end
      for (int i = 0; i < 4; i++) begin
         rd(4 + i, rv);
         n_vec++;
         if (rv !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL incr_mem[%0d] got %h want %h", 4 + i, rv, 32'hA0 + 32'(i)); end
      end
   endtask

   task automatic test_fixed();
      set_beats(2, 32'h0, 4'h6);
      tv_data[0] = 32'h11; tv_data[1] = 32'h22; tv_data[2] = 32'h33;
      tv_strb[0] = 4'h1;   tv_strb[1] = 4'h2;   tv_strb[2] = 4'hF;
      run_txn(32'h20, 4'h6, 4'd2, 2'd0, 3'd2);
      n_vec++; if (got_bresp !== 2'd0) begin n_err++; $display("FAIL fixed_bresp got %h want 0", got_bresp); end
      rd(8, rv);
      n_vec++; if (rv !== 32'h33) begin n_err++; $display("FAIL fixed_mem8 got %h want 00000033", rv); end
   endtask

   task automatic test_wrap();
      set_beats(3, 32'hC0, 4'h0);
      run_txn(32'h30, 4'h0, 4'd3, 2'd1, 3'd2);
      set_beats(3, 32'hB0, 4'h7);
      run_txn(32'h38, 4'h7, 4'd3, 2'd2, 3'd2);
`ifdef AXI_WR_SLV_WRAP_EN
      n_vec++; if (got_bresp !== 2'd0) begin n_err++; $display("FAIL wrap_bresp got %h want 0", got_bresp); end
      rd(14, rv); n_vec++; if (rv !== 32'hB0) begin n_err++; $display("FAIL wrap_mem14 got %h want b0", rv); end
      rd(15, rv); n_vec++; if (rv !== 32'hB1) begin n_err++; $display("FAIL wrap_mem15 got %h want b1", rv); end
      rd(12, rv); n_vec++; if (rv !== 32'hB2) begin n_err++; $display("FAIL wrap_mem12 got %h want b2", rv); end
      rd(13, rv); n_vec++; if (rv !== 32'hB3) begin n_err++; $display("FAIL wrap_mem13 got %h want b3", rv); end
`else
      n_vec++; if (got_bresp !== 2'd2) begin n_err++; $display("FAIL wrap_off_bresp got %h want 2", got_bresp); end
      for (int i = 0; i < 4; i++) begin
         rd(12 + i, rv);
         n_vec++;
         if (rv !== 32'hC0 + 32'(i)) begin n_err++; $display("FAIL wrap_off_mem[%0d] got %h want %h", 12 + i, rv, 32'hC0 + 32'(i)); end
      end
`endif
   endtask

   task automatic test_errors();
      // address one past the end of memory
      wsingle(0, 32'h1234_5678);
      set_beats(0, 32'hEE, 4'h1);
      run_txn(32'(DEPTH * 4), 4'h1, 4'd0, 2'd1, 3'd2);
      n_vec++; if (got_bresp !== 2'd2) begin n_err++; $display("FAIL oor_bresp got %h want 2", got_bresp); end
      rd(0, rv); n_vec++; if (rv !== 32'h1234_5678) begin n_err++; $display("FAIL oor_mem0 got %h want 12345678", rv); end
      // wrong wid on beat 1
      wsingle(17, 32'h5A5A_0017);
      set_beats(3, 32'hD0, 4'h3);
      tv_wid[1] = 4'h4;
      run_txn(32'h40, 4'h3, 4'd3, 2'd1, 3'd2);
      n_vec++; if (got_bresp !== 2'd2) begin n_err++; $display("FAIL wid_bresp got %h want 2", got_bresp); end
      n_vec++; if (got_bid !== 4'h3) begin n_err++; $display("FAIL wid_bid got %h want 3", got_bid); end
      rd(16, rv); n_vec++; if (rv !== 32'hD0) begin n_err++; $display("FAIL wid_mem16 got %h want d0", rv); end
      rd(17, rv); n_vec++; if (rv !== 32'h5A5A_0017) begin n_err++; $display("FAIL wid_mem17 got %h want 5a5a0017", rv); end
      rd(18, rv); n_vec++; if (rv !== 32'hD2) begin n_err++; $display("FAIL wid_mem18 got %h want d2", rv); end
      // early wlast on beat 1 of 4: burst still runs all 4 beats
      set_beats(3, 32'hE0, 4'h2);
      tv_last[1] = 1'b1; tv_last[3] = 1'b0;
      run_txn(32'h50, 4'h2, 4'd3, 2'd1, 3'd2);
      n_vec++; if (got_bresp !== 2'd2) begin n_err++; $display("FAIL wlast_bresp got %h want 2", got_bresp); end
      n_vec++; if (b_cyc - aw_cyc !== 5) begin n_err++; $display("FAIL wlast_len got %0d want 5", b_cyc - aw_cyc); end
      rd(23, rv); n_vec++; if (rv !== 32'hE3) begin n_err++; $display("FAIL wlast_mem23 got %h want e3", rv); end
      // awsize=3 blocks every write
      wsingle(24, 32'h2424_2424);
      set_beats(1, 32'hF0, 4'h1);
      run_txn(32'h60, 4'h1, 4'd1, 2'd1, 3'd3);
      n_vec++; if (got_bresp !== 2'd2) begin n_err++; $display("FAIL size_bresp got %h want 2", got_bresp); end
      rd(24, rv); n_vec++; if (rv !== 32'h2424_2424) begin n_err++; $display("FAIL size_mem24 got %h want 24242424", rv); end
   endtask

   task automatic test_bready_hold();
      int t = 0;
      set_beats(0, 32'h77, 4'h9);
      aw_phase(32'h70, 4'h9, 4'd0, 2'd1, 3'd2);
      w_beats(0, 1);
      while (bvalid !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (bvalid !== 1'b1 || bid !== 4'h9 || bresp !== 2'd0 || awready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_cycle%0d got bvalid=%b bid=%h bresp=%h awready=%b want 1 9 0 0", i, bvalid, bid, bresp, awready);
         end
         @(negedge aclk);
      end
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      n_vec++; if (awready !== 1'b1 || bvalid !== 1'b0) begin n_err++; $display("FAIL hold_release got awready=%b bvalid=%b want 1 0", awready, bvalid); end
      rd(28, rv); n_vec++; if (rv !== 32'h77) begin n_err++; $display("FAIL hold_mem28 got %h want 77", rv); end
   endtask

   task automatic test_back_to_back();
      int b1;
      set_beats(0, 32'h90, 4'h1);
      run_txn(32'h74, 4'h1, 4'd0, 2'd1, 3'd2);
      b1 = b_cyc;
      n_vec++; if (b_cyc - aw_cyc !== 2) begin n_err++; $display("FAIL b2b_single got %0d want 2", b_cyc - aw_cyc); end
      set_beats(0, 32'h91, 4'h2);
      run_txn(32'h78, 4'h2, 4'd0, 2'd1, 3'd2);
      n_vec++; if (aw_cyc - b1 !== 1) begin n_err++; $display("FAIL b2b_next_aw got %0d want 1", aw_cyc - b1); end
      rd(29, rv); n_vec++; if (rv !== 32'h90) begin n_err++; $display("FAIL b2b_mem29 got %h want 90", rv); end
      rd(30, rv); n_vec++; if (rv !== 32'h91) begin n_err++; $display("FAIL b2b_mem30 got %h want 91", rv); end
   endtask

   task automatic test_reset_mid();
      wsingle(34, 32'h3434_3434);
      set_beats(3, 32'h80, 4'h4);
      aw_phase(32'h80, 4'h4, 4'd3, 2'd1, 3'd2);
      w_beats(0, 2);
      arst = 1'b0;
      #1;
      n_vec++;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'h0 || bresp !== 2'd0) begin
         n_err++;
         $display("FAIL midrst_outputs got aw=%b w=%b bv=%b bid=%h bresp=%h want 0 0 0 0 0", awready, wready, bvalid, bid, bresp);
      end
      @(negedge aclk);
      arst = 1'b1;
      @(negedge aclk);
      rd(32, rv); n_vec++; if (rv !== 32'h80) begin n_err++; $display("FAIL midrst_mem32 got %h want 80", rv); end
      rd(33, rv); n_vec++; if (rv !== 32'h81) begin n_err++; $display("FAIL midrst_mem33 got %h want 81", rv); end
      rd(34, rv); n_vec++; if (rv !== 32'h3434_3434) begin n_err++; $display("FAIL midrst_mem34 got %h want 34343434", rv); end
      set_beats(0, 32'h99, 4'h6);
      run_txn(32'h8C, 4'h6, 4'd0, 2'd1, 3'd2);
      n_vec++; if (got_bresp !== 2'd0 || got_bid !== 4'h6) begin n_err++; $display("FAIL midrst_after got bresp=%h bid=%h want 0 6", got_bresp, got_bid); end
      rd(35, rv); n_vec++; if (rv !== 32'h99) begin n_err++; $display("FAIL midrst_mem35 got %h want 99", rv); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      @(negedge aclk);
      test_reset();
      test_incr();
      test_fixed();
      test_wrap();
      test_errors();
      test_bready_hold();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
